// File: rtl/blit_write_queue_if.sv
// Bus bundle between the blitter merge stage, the write queue and the
// memory arbiter. The queue sits on the slave side; the environment
// (blitter pipeline plus arbiter) sits on the master side.
interface blit_write_queue_if;

    // Merged word writes coming out of pipeline stage 5
    logic [25:0] p5_addr;
    logic [31:0] p5_data;
    logic [3:0]  p5_byte_enable;
    logic        p5_write;
    logic        stall;

    // Word write requests towards the memory arbiter
    logic        mem_request;
    logic [25:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_ack;

    // Environment view: drives pushes and acks, observes stall and requests
    modport master (
        output p5_addr,
        output p5_data,
        output p5_byte_enable,
        output p5_write,
        input  stall,
        input  mem_request,
        input  mem_addr,
        input  mem_wdata,
        input  mem_byte_enable,
        output mem_ack
    );

    // Queue view: accepts pushes, issues requests, raises stall
    modport slave (
        input  p5_addr,
        input  p5_data,
        input  p5_byte_enable,
        input  p5_write,
        output stall,
        output mem_request,
        output mem_addr,
        output mem_wdata,
        output mem_byte_enable,
        input  mem_ack
    );

endinterface

// File: rtl/blit_write_queue.sv
// Blitter write queue: buffers merged word writes in a small FIFO and
// hands them one at a time to the memory arbiter through a registered
// request/ack output stage. Stall is raised while enough free entries
// remain to absorb the words already in flight in the blitter pipeline,
// and drained tells the blitter that every write has been accepted.
module blit_write_queue #(
    parameter int DEPTH       = 8,
    parameter int STALL_SLACK = 3
) (
    input  logic               clock,
    input  logic               reset,
    blit_write_queue_if.slave  bus,
    output logic               drained,
    output logic               overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_LEVEL = CNT_W'(DEPTH - STALL_SLACK);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Only the word part of the address is kept; the low two bits are
    // always zero on the memory side.
    typedef struct packed {
        logic [23:0] word_addr;
        logic [31:0] data;
        logic [3:0]  byte_enable;
    } entry_t;

    entry_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    state_t             state;
    state_t             state_next;
    entry_t             head;
    logic               push_req;
    logic               pop;
    logic               push_accept;
    logic               unused_addr_bits;

    // Byte-offset bits of the incoming address carry no information here
    assign unused_addr_bits = ^bus.p5_addr[1:0];

    // Decide push/pop for this cycle and the resulting count and FSM state
    always_comb begin
        push_req    = bus.p5_write && (bus.p5_byte_enable != 4'b0000);
        pop         = (count != '0) && ((state == IDLE) || bus.mem_ack);
        push_accept = push_req && ((count < FULL_COUNT) || pop);
        count_next  = count + CNT_W'(push_accept) - CNT_W'(pop);
        head        = fifo_mem[rd_ptr];
        state_next  = state;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack && (count == '0)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clock) begin
        if (push_accept) begin
            fifo_mem[wr_ptr] <= '{word_addr:   bus.p5_addr[25:2],
                                  data:        bus.p5_data,
                                  byte_enable: bus.p5_byte_enable};
        end
    end

    // Pointers, count, output register FSM and registered status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            state               <= IDLE;
            bus.mem_request     <= 1'b0;
            bus.mem_addr        <= '0;
            bus.mem_wdata       <= '0;
            bus.mem_byte_enable <= '0;
            bus.stall           <= 1'b0;
            overflow            <= 1'b0;
            drained             <= 1'b1;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr              <= rd_ptr + PTR_W'(1);
                bus.mem_addr        <= {head.word_addr, 2'b00};
                bus.mem_wdata       <= head.data;
                bus.mem_byte_enable <= head.byte_enable;
            end
            if (push_req && !push_accept) begin
                overflow <= 1'b1;
            end
            count           <= count_next;
            state           <= state_next;
            bus.mem_request <= (state_next == REQ);
            bus.stall       <= (count_next >= STALL_LEVEL);
            drained         <= (count_next == '0) && (state_next == IDLE);
        end
    end

endmodule

// File: tb/tb_blit_write_queue.sv
// Directed self-checking bench for blit_write_queue (DEPTH=8, STALL_SLACK=3).
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point, so every check sees the state right after an edge.
module tb_blit_write_queue;

    logic clock = 1'b0;
    logic reset;
    logic drained;
    logic overflow;
    int   compares   = 0;
    int   mismatches = 0;

    blit_write_queue_if bus();

    blit_write_queue #(
        .DEPTH       (8),
        .STALL_SLACK (3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .drained  (drained),
        .overflow (overflow)
    );

    // Free-running clock, period 10
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic        write,
                                 input logic [25:0] addr,
                                 input logic [31:0] data,
                                 input logic [3:0]  be,
                                 input logic        ack);
        bus.p5_write       = write;
        bus.p5_addr        = addr;
        bus.p5_data        = data;
        bus.p5_byte_enable = be;
        bus.mem_ack        = ack;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string       tag,
                               input logic [31:0] observed,
                               input logic [31:0] expected);
        compares++;
        assert (observed === expected) else begin
            mismatches++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Pushed address carries junk in the byte-offset bits; expected drops them
    function automatic logic [25:0] pushAddr(input logic [25:0] base, input int i);
        return base + 26'(4 * i) + 26'(i % 4);
    endfunction

    function automatic logic [25:0] wordAddr(input logic [25:0] base, input int i);
        return base + 26'(4 * i);
    endfunction

    function automatic logic [31:0] wordData(input logic [31:0] base, input int i);
        return base + 32'(i);
    endfunction

    initial begin
        // Reset state
        applyStimulus(1'b0, 26'h0, 32'h0, 4'h0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        checkOutput("rst_mem_request", 32'(bus.mem_request), 32'h0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        checkOutput("rst_mem_be", 32'(bus.mem_byte_enable), 32'h0);
        checkOutput("rst_overflow", 32'(overflow), 32'h0);
        checkOutput("rst_stall", 32'(bus.stall), 32'h0);
        checkOutput("rst_drained", 32'(drained), 32'h1);
        reset = 1'b0;

        // Single push with ack tied high: request appears on the second edge
        applyStimulus(1'b1, 26'h0001237, 32'hAABBCCDD, 4'b0011, 1'b1);
        tick();
        applyStimulus(1'b0, 26'h0, 32'h0, 4'h0, 1'b1);
        checkOutput("t1_req_edge1", 32'(bus.mem_request), 32'h0);
        checkOutput("t1_drained_edge1", 32'(drained), 32'h0);
        tick();
        checkOutput("t1_req_edge2", 32'(bus.mem_request), 32'h1);
        checkOutput("t1_addr", 32'(bus.mem_addr), 32'h0001234);
        checkOutput("t1_be", 32'(bus.mem_byte_enable), 32'h3);
        checkOutput("t1_wdata", bus.mem_wdata, 32'hAABBCCDD);
        tick();
        checkOutput("t1_req_done", 32'(bus.mem_request), 32'h0);
        checkOutput("t1_drained_done", 32'(drained), 32'h1);

        // Fill with ack held low. Word 0 moves into the output register,
        // so after push i (i>=1) the FIFO holds i words: count reaches 5 on
        // push 5, 8 on push 8, and push 9 is the one that gets dropped.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, pushAddr(26'h100, i), wordData(32'hD0000000, i), 4'hF, 1'b0);
            tick();
            if (i == 4) checkOutput("t2_stall_cnt4", 32'(bus.stall), 32'h0);
            if (i == 5) checkOutput("t2_stall_cnt5", 32'(bus.stall), 32'h1);
            if (i == 8) checkOutput("t2_ovf_full", 32'(overflow), 32'h0);
        end
        checkOutput("t2_ovf_drop", 32'(overflow), 32'h1);
        applyStimulus(1'b0, 26'h0, 32'h0, 4'h0, 1'b0);
        tick();
        checkOutput("t2_hold_req", 32'(bus.mem_request), 32'h1);
        checkOutput("t2_hold_addr", 32'(bus.mem_addr), 32'(wordAddr(26'h100, 0)));
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(1'b0, 26'h0, 32'h0, 4'h0, 1'b1);
            tick();
            checkOutput($sformatf("t2_addr%0d", j), 32'(bus.mem_addr), 32'(wordAddr(26'h100, j)));
            checkOutput($sformatf("t2_data%0d", j), bus.mem_wdata, wordData(32'hD0000000, j));
        end
        checkOutput("t2_stall_low", 32'(bus.stall), 32'h0);
        tick();
        checkOutput("t2_req_done", 32'(bus.mem_request), 32'h0);
        checkOutput("t2_drained", 32'(drained), 32'h1);
        checkOutput("t2_ovf_sticky", 32'(overflow), 32'h1);

        // Streaming push every cycle with ack high: one word per cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, pushAddr(26'h200, i), wordData(32'h30000000, i), 4'hC, 1'b1);
            tick();
            if (i >= 1) begin
                checkOutput($sformatf("t3_req%0d", i), 32'(bus.mem_request), 32'h1);
                checkOutput($sformatf("t3_addr%0d", i), 32'(bus.mem_addr), 32'(wordAddr(26'h200, i - 1)));
            end
            checkOutput($sformatf("t3_stall%0d", i), 32'(bus.stall), 32'h0);
            checkOutput($sformatf("t3_ovf%0d", i), 32'(overflow), 32'h0);
        end
        applyStimulus(1'b0, 26'h0, 32'h0, 4'h0, 1'b1);
        tick();
        checkOutput("t3_last_addr", 32'(bus.mem_addr), 32'(wordAddr(26'h200, 9)));
        tick();
        checkOutput("t3_req_done", 32'(bus.mem_request), 32'h0);
        checkOutput("t3_drained", 32'(drained), 32'h1);

        // Full FIFO, then push together with ack: push must be accepted
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, pushAddr(26'h300, i), wordData(32'h40000000, i), 4'hF, 1'b0);
            tick();
        end
        checkOutput("t4_stall_full", 32'(bus.stall), 32'h1);
        checkOutput("t4_ovf_full", 32'(overflow), 32'h0);
        applyStimulus(1'b1, pushAddr(26'h300, 9), wordData(32'h40000000, 9), 4'hF, 1'b1);
        tick();
        checkOutput("t4_addr1", 32'(bus.mem_addr), 32'(wordAddr(26'h300, 1)));
        checkOutput("t4_ovf_same", 32'(overflow), 32'h0);
        checkOutput("t4_stall_same", 32'(bus.stall), 32'h1);
        applyStimulus(1'b0, 26'h0, 32'h0, 4'h0, 1'b0);
        tick();
        checkOutput("t4_ovf_after", 32'(overflow), 32'h0);
        for (int j = 2; j <= 9; j++) begin
            applyStimulus(1'b0, 26'h0, 32'h0, 4'h0, 1'b1);
            tick();
            checkOutput($sformatf("t4_addr%0d", j), 32'(bus.mem_addr), 32'(wordAddr(26'h300, j)));
        end
        checkOutput("t4_data9", bus.mem_wdata, wordData(32'h40000000, 9));
        tick();
        checkOutput("t4_req_done", 32'(bus.mem_request), 32'h0);
        checkOutput("t4_drained", 32'(drained), 32'h1);

        // Write strobe with no byte enables stores nothing
        applyStimulus(1'b1, 26'h0000500, 32'h00000055, 4'b0000, 1'b0);
        tick();
        checkOutput("t5_drained_edge1", 32'(drained), 32'h1);
        applyStimulus(1'b0, 26'h0, 32'h0, 4'h0, 1'b0);
        tick();
        checkOutput("t5_req", 32'(bus.mem_request), 32'h0);
        checkOutput("t5_drained_edge2", 32'(drained), 32'h1);

        // Reset in the middle of a transfer with 3 words queued behind it
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, pushAddr(26'h400, i), wordData(32'h60000000, i), 4'hF, 1'b0);
            tick();
        end
        checkOutput("t6_req_before", 32'(bus.mem_request), 32'h1);
        checkOutput("t6_drained_before", 32'(drained), 32'h0);
        applyStimulus(1'b0, 26'h0, 32'h0, 4'h0, 1'b0);
        reset = 1'b1;
        tick();
        checkOutput("t6_req_reset", 32'(bus.mem_request), 32'h0);
        checkOutput("t6_drained_reset", 32'(drained), 32'h1);
        checkOutput("t6_addr_reset", 32'(bus.mem_addr), 32'h0);
        reset = 1'b0;
        applyStimulus(1'b0, 26'h0, 32'h0, 4'h0, 1'b1);
        tick();
        tick();
        checkOutput("t6_req_after", 32'(bus.mem_request), 32'h0);
        checkOutput("t6_drained_after", 32'(drained), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
